mmio_sw_in: RTL

// - Memory-mapped switch input responder: the read-side counterpart of the LED output register.
// - Synchronizes and debounces SW_in, and latches change events.
// - Answers processor loads/stores on the data bus at BASE_ADDR.. and drives a hit flag.
// - The top level uses hit to mux data_out onto the processor read path and to block DMEM writes.

---
 rtl/mmio_sw_in.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mmio_sw_in.sv
// Memory-mapped switch input block: synchronizes, debounces and edge-latches SW_in.
// Optional SW_IRQ_EN adds the SW_MASK register and a registered irq output.
module mmio_sw_in #(
  parameter int unsigned WIDTH      = 10,
  parameter logic [15:0] BASE_ADDR  = 16'hC001,
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned DB_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SW_in,
  input  logic [15:0]      daddr,
  input  logic             en,
  input  logic             wr,
  input  logic [15:0]      data_in,
  output logic [15:0]      data_out,
  output logic             hit
`ifdef SW_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW = $clog2(DB_SAMPLES + 1);
  localparam logic [15:0] ADDR_STATE = BASE_ADDR;
  localparam logic [15:0] ADDR_EDGE  = BASE_ADDR + 16'd1;
`ifdef SW_IRQ_EN
  localparam logic [15:0] ADDR_MASK  = BASE_ADDR + 16'd2;
`endif

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] edge_clr;
  logic             tick;
  logic             sel_state;
  logic             sel_edge;
  logic             data_in_unused;
`ifdef SW_IRQ_EN
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;
  logic             sel_mask;
`endif

  // Only the low WIDTH bits of a store carry meaning.
  assign data_in_unused = ^data_in;

  always_comb begin
    sel_state = en && (daddr == ADDR_STATE);
    sel_edge  = en && (daddr == ADDR_EDGE);
`ifdef SW_IRQ_EN
    sel_mask  = en && (daddr == ADDR_MASK);
`endif
    hit      = 1'b0;
    data_out = '0;
    if (sel_state) begin
      hit      = 1'b1;
      data_out = 16'(db_q);
    end else if (sel_edge) begin
      hit      = 1'b1;
      data_out = 16'(edge_q);
    end
`ifdef SW_IRQ_EN
    else if (sel_mask) begin
      hit      = 1'b1;
      data_out = 16'(mask_q);
    end
`endif
  end

  always_comb begin
    sync1_d = SW_in;
    sync2_d = sync1_q;
    tick    = (presc_q == PW'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);

    db_d = db_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != db_q[i]) begin
          if (cnt_q[i] + CW'(1) == CW'(DB_SAMPLES)) begin
            db_d[i]  = ~db_q[i];
            cnt_d[i] = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end

    // New edges are OR-ed in after the W1C mask so a same-cycle set wins.
    edge_clr = (wr && sel_edge) ? data_in[WIDTH-1:0] : '0;
    edge_d   = (edge_q & ~edge_clr) | (db_d ^ db_q);

`ifdef SW_IRQ_EN
    mask_d = (wr && sel_mask) ? data_in[WIDTH-1:0] : mask_q;
    irq_d  = |(edge_q & mask_q);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      db_q    <= '0;
      edge_q  <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
`ifdef SW_IRQ_EN
      mask_q  <= '0;
      irq_q   <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      db_q    <= db_d;
      edge_q  <= edge_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
`ifdef SW_IRQ_EN
      mask_q  <= mask_d;
      irq_q   <= irq_d;
`endif
    end
  end

`ifdef SW_IRQ_EN
  assign irq = irq_q;
`endif

endmodule
